// File: rtl/lem_mem_loader_if.sv
// lem_mem_loader_if: command, DCPU memory read, default ROM and local RAM write
// signals of the LEM1802 memory loader. 'master' is the loader side, 'slave'
// is the surrounding system (command source, memory, ROM, local RAMs).
interface lem_mem_loader_if;
    // HWI command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_arg;

    // DCPU main memory read port
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;

    // Default font/palette ROM (1-cycle read latency)
    logic [8:0]  dflt_addr;
    logic [15:0] dflt_data;

    // Local RAM write port
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_arg,
        output cmd_ready,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output dflt_addr,
        input  dflt_data,
        output wr_en, wr_sel, wr_addr, wr_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_arg,
        input  cmd_ready,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  dflt_addr,
        output dflt_data,
        input  wr_en, wr_sel, wr_addr, wr_data
    );
endinterface

// File: rtl/lem_mem_loader.sv
// lem_mem_loader: LEM1802 bus-side writer. Holds the screen/font/palette
// mapping and border registers set by HWI commands, and once per frame copies
// the mapped DCPU memory regions into VRAM, font RAM and palette RAM.
// Optional feature macro LEM_DEFAULT_ROM_EN: when defined, unmapped font and
// palette phases are refilled from the default ROM; when undefined they are
// skipped and dflt_addr is tied to zero.
module lem_mem_loader #(
    parameter int unsigned VRAM_WORDS = 384,
    parameter int unsigned FONT_WORDS = 256,
    parameter int unsigned PAL_WORDS  = 16
) (
    input  logic              CLOCK_25M,
    input  logic              RST_n,
    lem_mem_loader_if.master  bus,
    input  logic              frame_start,
    output logic              busy,
    output logic [3:0]        borderColour,
    output logic              screen_on
);

    typedef enum logic [1:0] {IDLE, SCREEN, FONT, PAL} state_t;
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_WRITE, ST_ROM} step_t;

    localparam logic [8:0] VRAM_LAST = 9'(VRAM_WORDS - 1);
    localparam logic [8:0] FONT_LAST = 9'(FONT_WORDS - 1);
    localparam logic [8:0] PAL_LAST  = 9'(PAL_WORDS - 1);

`ifdef LEM_DEFAULT_ROM_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif

    state_t      state;
    step_t       step;
    logic [15:0] screen_base;
    logic [15:0] font_base;
    logic [15:0] pal_base;
    logic [3:0]  border;
    logic        screen_on_q;
    logic        pending;
    logic [8:0]  idx;

    logic        mem_req_q;
    logic [15:0] mem_addr_q;
    logic        wr_en_q;
    logic [1:0]  wr_sel_q;
    logic [8:0]  wr_addr_q;
    logic [15:0] wr_data_q;

`ifdef LEM_DEFAULT_ROM_EN
    logic [8:0]  dflt_addr_q;
    logic [8:0]  ridx;
    logic        raddr_live;
    logic        dvalid;
`endif

    logic        cmd_acc;
    logic        start_refresh;
    logic        last_write;
    logic        enter_now;
    state_t      after_font;
    state_t      after_screen;
    state_t      start_phase;
    state_t      enter_phase;
    logic [15:0] enter_base;
    logic [1:0]  enter_sel;
    logic [8:0]  enter_rom;
    logic [8:0]  phase_last;

    // Phase sequencing: resolve which phase comes next (skipping unmapped
    // phases that have no source) so the next phase's first request can be
    // issued the cycle right after the previous phase's last write.
    always_comb begin
        after_font   = ((pal_base != '0) || ROM_EN) ? PAL : IDLE;
        after_screen = ((font_base != '0) || ROM_EN) ? FONT : after_font;
        start_phase  = (screen_base != '0) ? SCREEN : after_screen;

        unique case (state)
            IDLE:    enter_phase = start_phase;
            SCREEN:  enter_phase = after_screen;
            FONT:    enter_phase = after_font;
            default: enter_phase = IDLE;
        endcase

        enter_base = '0;
        enter_sel  = 2'd0;
        enter_rom  = '0;
        unique case (enter_phase)
            SCREEN: begin enter_base = screen_base; enter_sel = 2'd0; end
            FONT:   begin enter_base = font_base;   enter_sel = 2'd1; enter_rom = 9'd0;   end
            PAL:    begin enter_base = pal_base;    enter_sel = 2'd2; enter_rom = 9'd256; end
            default: ;
        endcase

        unique case (state)
            SCREEN:  phase_last = VRAM_LAST;
            FONT:    phase_last = FONT_LAST;
            PAL:     phase_last = PAL_LAST;
            default: phase_last = '0;
        endcase

        cmd_acc       = bus.cmd_valid && (state == IDLE);
        start_refresh = (state == IDLE) && !cmd_acc && (pending || frame_start);
        last_write    = (state != IDLE) && wr_en_q && (wr_addr_q == phase_last);
        enter_now     = start_refresh || last_write;
    end

    // Command registers, frame pending flag and the copy FSM with its
    // registered memory/ROM/write outputs.
    always_ff @(posedge CLOCK_25M or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            step        <= ST_REQ;
            screen_base <= '0;
            font_base   <= '0;
            pal_base    <= '0;
            border      <= '0;
            screen_on_q <= 1'b0;
            pending     <= 1'b0;
            idx         <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 2'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef LEM_DEFAULT_ROM_EN
            dflt_addr_q <= '0;
            ridx        <= '0;
            raddr_live  <= 1'b0;
            dvalid      <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;

            if (cmd_acc) begin
                unique case (bus.cmd_op)
                    3'd0: begin
                        screen_base <= bus.cmd_arg;
                        screen_on_q <= (bus.cmd_arg != '0);
                    end
                    3'd1:    font_base <= bus.cmd_arg;
                    3'd2:    pal_base  <= bus.cmd_arg;
                    3'd3:    border    <= bus.cmd_arg[3:0];
                    default: ;
                endcase
            end

            if (start_refresh) begin
                pending <= 1'b0;
            end else if (frame_start) begin
                pending <= 1'b1;
            end

            if (state != IDLE) begin
                unique case (step)
                    ST_REQ: begin
                        if (bus.mem_gnt) begin
                            mem_req_q <= 1'b0;
                            step      <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.mem_rvalid) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= bus.mem_rdata;
                            wr_addr_q <= idx;
                            step      <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (!last_write) begin
                            idx        <= idx + 9'd1;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= mem_addr_q + 16'd1;
                            step       <= ST_REQ;
                        end
                    end
                    ST_ROM: begin
`ifdef LEM_DEFAULT_ROM_EN
                        // Address, data and write form a 3-stage pipeline.
                        if (dvalid) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= bus.dflt_data;
                            wr_addr_q <= idx;
                            idx       <= idx + 9'd1;
                        end
                        dvalid <= raddr_live;
                        if (raddr_live) begin
                            if (ridx == phase_last) begin
                                raddr_live <= 1'b0;
                            end else begin
                                ridx        <= ridx + 9'd1;
                                dflt_addr_q <= dflt_addr_q + 9'd1;
                            end
                        end
`endif
                    end
                    default: ;
                endcase
            end

            if (enter_now) begin
                state <= enter_phase;
                idx   <= '0;
                if (enter_phase != IDLE) begin
                    wr_sel_q <= enter_sel;
                    if (enter_base != '0) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= enter_base;
                        step       <= ST_REQ;
                    end else begin
`ifdef LEM_DEFAULT_ROM_EN
                        step        <= ST_ROM;
                        dflt_addr_q <= enter_rom;
                        ridx        <= '0;
                        raddr_live  <= 1'b1;
                        dvalid      <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign borderColour  = border;
    assign screen_on     = screen_on_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_sel    = wr_sel_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

`ifdef LEM_DEFAULT_ROM_EN
    assign bus.dflt_addr = dflt_addr_q;
`else
    logic unused_dflt;
    logic unused_rom_base;
    assign bus.dflt_addr     = '0;
    assign unused_dflt       = ^bus.dflt_data;
    assign unused_rom_base   = ^enter_rom;
`endif

endmodule
